// File: rtl/rv_pc_unit.sv
// rv_pc_unit: fetch PC generator with EX-stage redirects, a one-entry pending redirect and a multi-cycle IF/ID flush.
// Optional RV_PC_MISALIGN_TRAP_EN: misaligned targets trap to TRAP_VECTOR instead of being force-aligned.
module rv_pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            busy,
  input  logic            redir_valid,
  input  logic [2:0]      pc_opsel,
  input  logic            branch_taken,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] reg_s1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] return_addr,
  output logic            flush,
  output logic            halt,
  output logic            trap,
  output logic [XLEN-1:0] trap_tval
);

  localparam int unsigned   CW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;

  logic [XLEN-1:0] imm_i, imm_j, imm_b;
  logic [XLEN-1:0] jalr_sum, raw_tgt, apply_tgt, load_pc;
  logic            take, adv, apply;

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign jalr_sum = reg_s1 + imm_i;

  always_comb begin
    raw_tgt = ex_pc + imm_b;
    case (pc_opsel)
      3'd0:    raw_tgt = ex_pc + imm_j;
      3'd1:    raw_tgt = {jalr_sum[XLEN-1:1], 1'b0};
      default: raw_tgt = ex_pc + imm_b;
    endcase
  end

  assign take  = redir_valid & ((pc_opsel < 3'd2) | branch_taken);
  assign adv   = enable & ~busy;
  // A held redirect is older than whatever EX offers now, so it always wins.
  assign apply     = adv & (pending_q | take);
  assign apply_tgt = pending_q ? pend_tgt_q : raw_tgt;

`ifdef RV_PC_MISALIGN_TRAP_EN
  logic            misaligned;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_tval_q, trap_tval_d;
  logic            unused_tgt_lsb;

  assign misaligned     = apply_tgt[1];
  assign load_pc        = misaligned ? TRAP_VECTOR : apply_tgt;
  assign unused_tgt_lsb = apply_tgt[0];

  always_comb begin
    trap_d      = apply & misaligned;
    trap_tval_d = trap_tval_q;
    if (apply && misaligned) begin
      trap_tval_d = apply_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q      <= 1'b0;
      trap_tval_q <= '0;
    end else begin
      trap_q      <= trap_d;
      trap_tval_q <= trap_tval_d;
    end
  end

  assign trap      = trap_q;
  assign trap_tval = trap_tval_q;
`else
  logic unused_misalign;

  assign load_pc         = {apply_tgt[XLEN-1:2], 2'b00};
  assign unused_misalign = ^{apply_tgt[1:0], TRAP_VECTOR};
  assign trap            = 1'b0;
  assign trap_tval       = '0;
`endif

  always_comb begin
    pc_d        = pc_q;
    pending_d   = pending_q;
    pend_tgt_d  = pend_tgt_q;
    flush_cnt_d = flush_cnt_q;
    if (adv) begin
      if (flush_cnt_q != '0) begin
        flush_cnt_d = flush_cnt_q - CW'(1);
      end
      if (apply) begin
        pc_d        = load_pc;
        pending_d   = 1'b0;
        flush_cnt_d = FLUSH_LOAD;
      end else begin
        pc_d = pc_q + XLEN'(STEP);
      end
    end else if (take && !pending_q) begin
      // Stalled: park the redirect; a second one while parked is dropped.
      pend_tgt_d = raw_tgt;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      pending_q   <= 1'b0;
      pend_tgt_q  <= '0;
      flush_cnt_q <= FLUSH_LOAD;
    end else begin
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      pend_tgt_q  <= pend_tgt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc          = pc_q;
  assign flush       = (flush_cnt_q != '0);
  assign halt        = ~enable;
  assign return_addr = ex_pc + XLEN'(STEP);

endmodule
